// File: rtl/gray_counter.sv
// Parametrised up/down Gray-code counter with registered Gray and binary
// outputs, wrap/saturate mode, synchronous load (Gray or binary) and
// wrap/limit status flags. The binary and Gray registers are updated in
// lockstep, so gray_out always changes by exactly one bit per count step.
module gray_counter #(
    parameter int unsigned            p_width     = 4,
    parameter int unsigned            p_saturate  = 0,
    parameter logic [p_width-1:0]     p_reset_bin = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic               load_gray,
    input  logic [p_width-1:0] data_in,
    input  logic               en,
    input  logic               up,
    output logic [p_width-1:0] gray_out,
    output logic [p_width-1:0] bin_out,
    output logic               wrap_out,
    output logic               at_max,
    output logic               at_min
);

    localparam logic [p_width-1:0] c_max  = '1;
    localparam logic [p_width-1:0] c_zero = '0;
    localparam logic [p_width-1:0] c_one  = {{(p_width-1){1'b0}}, 1'b1};

    function automatic logic [p_width-1:0] bin2gray(input logic [p_width-1:0] bv);
        return bv ^ (bv >> 1);
    endfunction

    // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [p_width-1:0] gray2bin(input logic [p_width-1:0] gv);
        logic [p_width-1:0] r;
        r = '0;
        r[p_width-1] = gv[p_width-1];
        for (int i = p_width - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ gv[i];
        end
        return r;
    endfunction

    logic [p_width-1:0] b_q, b_d;
    logic [p_width-1:0] g_q, g_d;
    logic               w_q, w_d;
    logic               at_max_q, at_max_d;
    logic               at_min_q, at_min_d;

    // Next-state selection with priority clear > load > en > hold.
    always_comb begin
        b_d = b_q;
        w_d = 1'b0;
        if (clear) begin
            b_d = p_reset_bin;
        end else if (load) begin
            b_d = load_gray ? gray2bin(data_in) : data_in;
        end else if (en) begin
            if (up) begin
                if (b_q != c_max) begin
                    b_d = b_q + c_one;
                end else if (p_saturate == 0) begin
                    b_d = c_zero;
                    w_d = 1'b1;
                end
            end else begin
                if (b_q != c_zero) begin
                    b_d = b_q - c_one;
                end else if (p_saturate == 0) begin
                    b_d = c_max;
                    w_d = 1'b1;
                end
            end
        end
        // A Gray load keeps the supplied code verbatim; it equals the re-encode anyway.
        g_d      = (!clear && load && load_gray) ? data_in : bin2gray(b_d);
        at_max_d = (b_d == c_max);
        at_min_d = (b_d == c_zero);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q      <= p_reset_bin;
            g_q      <= bin2gray(p_reset_bin);
            w_q      <= 1'b0;
            at_max_q <= (p_reset_bin == c_max);
            at_min_q <= (p_reset_bin == c_zero);
        end else begin
            b_q      <= b_d;
            g_q      <= g_d;
            w_q      <= w_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign gray_out = g_q;
    assign bin_out  = b_q;
    assign wrap_out = w_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share one
// directed stimulus stream; an integer model tracks each and is compared
// every cycle, with literal expectations pinning key points.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       reset, clear, load, load_gray, en, up;
    logic [3:0] data_in;
    logic [3:0] gray_w, bin_w, gray_s, bin_s;
    logic       wrap_w, amax_w, amin_w, wrap_s, amax_s, amin_s;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    // model state: value, wrap flag, step kind (0 none, 1 counted step, 2 saturated hold)
    int mv_w = 0, mw_w = 0, mk_w = 0;
    int mv_s = 0, mw_s = 0, mk_s = 0;
    int pg_w = 0, pg_s = 0;

    always #5 clk = ~clk;

    gray_counter #(.p_width(4), .p_saturate(0), .p_reset_bin(4'd0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_gray(load_gray),
        .data_in(data_in), .en(en), .up(up), .gray_out(gray_w), .bin_out(bin_w),
        .wrap_out(wrap_w), .at_max(amax_w), .at_min(amin_w));

    gray_counter #(.p_width(4), .p_saturate(1), .p_reset_bin(4'd0)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_gray(load_gray),
        .data_in(data_in), .en(en), .up(up), .gray_out(gray_s), .bin_out(bin_s),
        .wrap_out(wrap_s), .at_max(amax_s), .at_min(amin_s));

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray by search: the value whose code matches.
    function automatic int from_gray(input int g);
        for (int k = 0; k < 16; k++) if (to_gray(k) == g) return k;
        return -1;
    endfunction

    task automatic mstep(input int sat, input int v_in, output int v, output int w, output int kind);
        v = v_in; w = 0; kind = 0;
        if (reset || clear) v = 0;
        else if (load) v = load_gray ? from_gray(int'(data_in)) : int'(data_in);
        else if (en) begin
            if (up) begin
                if (v < 15) begin v = v + 1; kind = 1; end
                else if (sat != 0) kind = 2;
                else begin v = 0; w = 1; kind = 1; end
            end else begin
                if (v > 0) begin v = v - 1; kind = 1; end
                else if (sat != 0) kind = 2;
                else begin v = 15; w = 1; kind = 1; end
            end
        end
    endtask

    // Model advance on every active edge using the inputs that edge samples.
    always @(posedge clk) begin
        int v, w, k;
        mstep(0, mv_w, v, w, k); mv_w = v; mw_w = w; mk_w = k;
        mstep(1, mv_s, v, w, k); mv_s = v; mw_s = w; mk_s = k;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("w.bin",    int'(bin_w),  mv_w);
            chk("w.gray",   int'(gray_w), to_gray(mv_w));
            chk("w.wrap",   int'(wrap_w), mw_w);
            chk("w.at_max", int'(amax_w), int'(mv_w == 15));
            chk("w.at_min", int'(amin_w), int'(mv_w == 0));
            if (mk_w == 1) chk("w.gray_onebit", $countones(gray_w ^ 4'(pg_w)), 1);
            chk("s.bin",    int'(bin_s),  mv_s);
            chk("s.gray",   int'(gray_s), to_gray(mv_s));
            chk("s.wrap",   int'(wrap_s), mw_s);
            chk("s.at_max", int'(amax_s), int'(mv_s == 15));
            chk("s.at_min", int'(amin_s), int'(mv_s == 0));
            if (mk_s == 1) chk("s.gray_onebit", $countones(gray_s ^ 4'(pg_s)), 1);
            if (mk_s == 2) chk("s.gray_stable", int'(gray_s), pg_s);
        end
        pg_w = int'(gray_w);
        pg_s = int'(gray_s);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; clear = 0; load = 1; load_gray = 0; data_in = 4'd5; en = 1; up = 1;
        cyc(); cyc();
        chk_on = 1'b1;
        chk("lit.rst.bin",  int'(bin_w), 0);
        chk("lit.rst.gray", int'(gray_w), 0);
        chk("lit.rst.amin", int'(amin_w), 1);
        chk("lit.rst.amax", int'(amax_w), 0);
        chk("lit.rst.wrap", int'(wrap_w), 0);

        // wrap up through a full cycle
        reset = 0; load = 0; en = 1; up = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 1)  chk("lit.up1.gray", int'(gray_w), 4'b0001);
            if (i == 2)  chk("lit.up2.gray", int'(gray_w), 4'b0011);
            if (i == 3)  chk("lit.up3.gray", int'(gray_w), 4'b0010);
            if (i == 15) begin
                chk("lit.up15.bin",  int'(bin_w), 15);
                chk("lit.up15.gray", int'(gray_w), 4'b1000);
                chk("lit.up15.wrap", int'(wrap_w), 0);
            end
        end
        chk("lit.up16.bin",  int'(bin_w), 0);
        chk("lit.up16.wrap", int'(wrap_w), 1);
        chk("lit.sat16.bin", int'(bin_s), 15);
        chk("lit.sat16.wrap", int'(wrap_s), 0);

        // wrap down from zero
        up = 0; cyc();
        chk("lit.dn.bin",  int'(bin_w), 15);
        chk("lit.dn.gray", int'(gray_w), 4'b1000);
        chk("lit.dn.wrap", int'(wrap_w), 1);
        chk("lit.dn.amax", int'(amax_w), 1);
        en = 0; cyc();
        chk("lit.hold.wrap", int'(wrap_w), 0);

        // saturation up from 14
        load = 1; load_gray = 0; data_in = 4'd14; cyc();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("lit.satup.bin",  int'(bin_s), 15);
            chk("lit.satup.gray", int'(gray_s), 4'b1000);
            chk("lit.satup.wrap", int'(wrap_s), 0);
        end
        chk("lit.wrapup.bin", int'(bin_w), 1);

        // saturation down from 1
        load = 1; data_in = 4'd1; cyc();
        load = 0; en = 1; up = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("lit.satdn.bin",  int'(bin_s), 0);
            chk("lit.satdn.amin", int'(amin_s), 1);
        end
        chk("lit.wrapdn.bin", int'(bin_w), 14);

        // loads win over en
        load = 1; load_gray = 1; data_in = 4'b1101; en = 1; up = 1; cyc();
        chk("lit.ldg.bin",  int'(bin_w), 9);
        chk("lit.ldg.gray", int'(gray_w), 4'b1101);
        load_gray = 0; data_in = 4'd6; cyc();
        chk("lit.ldb.bin",  int'(bin_w), 6);
        chk("lit.ldb.gray", int'(gray_w), 4'b0101);

        // priority
        reset = 1; clear = 1; load = 1; data_in = 4'd9; en = 1; cyc();
        chk("lit.pri.all", int'(bin_w), 0);
        reset = 0; cyc();
        chk("lit.pri.clrld", int'(bin_w), 0);
        clear = 0; load = 0; en = 1; up = 1;
        repeat (7) cyc();
        chk("lit.cnt7", int'(bin_w), 7);
        reset = 1; cyc();
        chk("lit.midrst.bin",  int'(bin_w), 0);
        chk("lit.midrst.wrap", int'(wrap_w), 0);
        reset = 0;

        // clear right after a wrap drops the pulse
        load = 1; data_in = 4'd15; cyc();
        load = 0; cyc();
        chk("lit.wrap2.wrap", int'(wrap_w), 1);
        clear = 1; cyc();
        chk("lit.clr.bin",  int'(bin_w), 0);
        chk("lit.clr.wrap", int'(wrap_w), 0);
        clear = 0; en = 0; cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised up/down Gray-code counter with registered Gray and binary outputs.
- Source of glitch-free pointers and phase counters for CGRA FIFO/elastic-buffer logic: only one bit of gray_out changes per step.
- Successor to the combinational Gray decoder:
  - arbitrary width;
  - direction control;
  - wrap or saturate mode;
  - synchronous load from Gray or binary;
  - wrap/limit status.

Parameters:
- p_width, 4: counter width in bits; any value >= 2 (no power-of-2 restriction).
- p_saturate, 0: 0 = wrap modulo 2^p_width; 1 = hold at all-ones when counting up, hold at zero when counting down.
- p_reset_bin, 0: binary reset value. It must be < 2^p_width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous return to p_reset_bin.
- load  input  1  load data_in this cycle.
- load_gray  input  1  1 = data_in is Gray-coded; 0 = data_in is binary.
- data_in  input  p_width  load value.
- en  input  1  count enable.
- up  input  1  1 = increment, 0 = decrement.
- gray_out  output  p_width  registered Gray count.
- bin_out  output  p_width  registered binary count, always equal to the decode of gray_out.
- wrap_out  output  1  registered one-cycle pulse; high in the cycle after a step crossed the max->0 or 0->max boundary.
- at_max  output  1  registered; high when bin_out == 2^p_width-1.
- at_min  output  1  registered; high when bin_out == 0.

Behaviour:
- State:
  - binary register b;
  - Gray register g = b ^ (b >> 1), held in lockstep;
  - wrap register w.
- All outputs come from registers. There is no combinational path from inputs to outputs. Latency is 1 cycle from input to output.
- Next-state priority, evaluated every rising edge: reset > clear > load > en > hold.
- reset:
  - b <= p_reset_bin; g <= Gray(p_reset_bin); w <= 0.
  - at_max and at_min reflect p_reset_bin.
  - Any operation in flight is discarded.
- clear: same values as reset.
- load:
  - If load_gray = 1: b <= decode(data_in), where bit i = XOR of data_in[p_width-1:i]; g <= data_in.
  - If load_gray = 0: b <= data_in; g <= Gray(data_in).
  - w <= 0.
  - en and up are ignored that cycle.
- en with up = 1:
  - Below max: b <= b+1.
  - At max with p_saturate = 0: b <= 0, w <= 1.
  - At max with p_saturate = 1: b holds, w <= 0.
- en with up = 0:
  - Above 0: b <= b-1.
  - At 0 with p_saturate = 0: b <= max, w <= 1.
  - At 0 with p_saturate = 1: b holds, w <= 0.
- Binary arithmetic is p_width bits, modulo 2^p_width. No carry-out exists beyond w.
- w is 0 in any cycle that does not wrap, including hold, load and clear. w is never high for two consecutive cycles unless wraps occur on consecutive edges.
- Gray invariant: across any en step, gray_out changes in exactly one bit. Across a saturating hold, no bit changes.
- at_max and at_min are mutually exclusive (p_width >= 2).
- Inputs sampled while reset is high are ignored. Counting resumes on the first edge after reset deasserts.

Test Plan:
- Reset, with p_width = 4, p_reset_bin = 0 -> bin_out = 0, gray_out = 4'b0000, at_min = 1, at_max = 0, wrap_out = 0.
- Wrap up: en = 1, up = 1 for 16 cycles from 0 -> bin_out 1..15 then 0. gray_out follows 0001, 0011, 0010, … 1000, 0000 with exactly one bit change per step. wrap_out is high only in the cycle bin_out returns to 0.
- Wrap down: from 0, en = 1, up = 0 -> bin_out = 15, gray_out = 4'b1000, wrap_out = 1 for one cycle, at_max = 1.
- Saturate (p_saturate = 1): count up from 14 for 3 cycles -> bin_out = 15 and held, gray_out stable, wrap_out stays 0. Count down from 1 for 3 cycles -> holds at 0.
- Load: load = 1, load_gray = 1, data_in = 4'b1101 -> bin_out = 9, gray_out = 4'b1101. load = 1, load_gray = 0, data_in = 6 -> gray_out = 4'b0101. With en = 1 in the same cycle, the load wins.
- Priority: reset, clear, load and en all asserted together -> reset values. clear with load in the same cycle -> p_reset_bin. Reset asserted mid-count at bin_out = 7 -> 0 on the next edge, with no wrap pulse.
